// File: rtl/pi_bus_master_if.sv
// pi_bus_master_if: command/response handshake and Pi register-port control signals.
// PI_D is bidirectional and stays a plain inout port on pi_bus_master.
interface pi_bus_master_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE;
    logic [1:0]  CMD_REG;
    logic [15:0] CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        RSP_ERR;
    logic        PI_REQ;
    logic        PI_WR;
    logic [1:0]  PI_A;
    logic        PI_ACK;
    logic        PI_IRQ;
    logic        IRQ_OUT;
    logic        BUSY;

    modport master (
        input  CMD_VALID, CMD_TYPE, CMD_REG, CMD_ADDR, CMD_WDATA, PI_ACK, PI_IRQ,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PI_REQ, PI_WR, PI_A, IRQ_OUT, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_TYPE, CMD_REG, CMD_ADDR, CMD_WDATA, PI_ACK, PI_IRQ,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PI_REQ, PI_WR, PI_A, IRQ_OUT, BUSY
    );
endinterface

// File: rtl/pi_bus_master.sv
// pi_bus_master: Pi-side initiator for the bridge's four-phase PI_REQ/PI_ACK register port.
// Turns single host commands into ordered register phases; SRAM accesses go A_LO, A_HI, DATA.
// Optional feature: define PI_ADDR_CACHE_EN to skip address phases whose byte is already
// loaded in the bridge (tracked by a last-written address cache).
module pi_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic            CLK,
    input  logic            RST,
    pi_bus_master_if.master bus,
    inout  wire [7:0]       PI_D
);
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned PEND_W   = 3;
    localparam logic [1:0]  REG_DATA = 2'd0;
    localparam logic [1:0]  REG_ALO  = 2'd2;
    localparam logic [1:0]  REG_AHI  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ, S_REL, S_DONE} state_t;

    // One bus phase: register index, direction and write data.
    typedef struct packed {
        logic [1:0] a;
        logic       wr;
        logic [7:0] d;
    } phase_t;

    state_t              state;
    logic                cmd_ready;
    logic                busy;
    logic                pi_req;
    logic                pi_wr;
    logic [1:0]          pi_a;
    logic [7:0]          pi_d_out;
    logic                pi_d_oe;
    logic                rsp_valid;
    logic [7:0]          rsp_rdata;
    logic                rsp_err;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [PEND_W-1:0]   pend_q;
    logic [1:0]          cmd_type_q;
    logic [1:0]          cmd_reg_q;
    logic [15:0]         cmd_addr_q;
    logic [7:0]          cmd_wdata_q;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                ack_s;

`ifdef PI_ADDR_CACHE_EN
    logic [15:0]         cache_addr;
    logic                cache_lo_vld;
    logic                cache_hi_vld;
`endif

    logic [PEND_W-1:0]   start_pend_c;
    logic [PEND_W-1:0]   rem_pend_c;
    phase_t              start_ph_c;
    phase_t              next_ph_c;
    logic                tmo_hit_c;

    // Pending bits: [0] A_LO, [1] A_HI, [2] main phase; lowest set bit is issued first.
    function automatic phase_t pick_phase(input logic [PEND_W-1:0] pend, input logic [1:0] ctype,
                                          input logic [1:0] creg, input logic [15:0] addr,
                                          input logic [7:0] wdata);
        phase_t p;
        p.a  = ctype[1] ? REG_DATA : creg;
        p.wr = ~ctype[0];
        p.d  = wdata;
        if (pend[0]) begin
            p.a  = REG_ALO;
            p.wr = 1'b1;
            p.d  = addr[7:0];
        end else if (pend[1]) begin
            p.a  = REG_AHI;
            p.wr = 1'b1;
            p.d  = addr[15:8];
        end
        return p;
    endfunction

    // Phase list for a newly offered command and the follow-on phase of the current one.
    always_comb begin
        start_pend_c = {1'b1, bus.CMD_TYPE[1], bus.CMD_TYPE[1]};
`ifdef PI_ADDR_CACHE_EN
        if (cache_lo_vld && (cache_addr[7:0] == bus.CMD_ADDR[7:0])) begin
            start_pend_c[0] = 1'b0;
        end
        if (cache_hi_vld && (cache_addr[15:8] == bus.CMD_ADDR[15:8])) begin
            start_pend_c[1] = 1'b0;
        end
`endif
        rem_pend_c = pend_q & (pend_q - PEND_W'(1));
        start_ph_c = pick_phase(start_pend_c, bus.CMD_TYPE, bus.CMD_REG, bus.CMD_ADDR, bus.CMD_WDATA);
        next_ph_c  = pick_phase(rem_pend_c, cmd_type_q, cmd_reg_q, cmd_addr_q, cmd_wdata_q);
        tmo_hit_c  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    end

    // Synchronise the asynchronous PI_ACK and PI_IRQ inputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_sync <= '0;
            irq_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.PI_ACK};
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], bus.PI_IRQ};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            pi_req      <= 1'b0;
            pi_wr       <= 1'b0;
            pi_a        <= 2'd0;
            pi_d_out    <= 8'd0;
            pi_d_oe     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_err     <= 1'b0;
            tmo_cnt     <= '0;
            pend_q      <= '0;
            cmd_type_q  <= 2'd0;
            cmd_reg_q   <= 2'd0;
            cmd_addr_q  <= 16'd0;
            cmd_wdata_q <= 8'd0;
`ifdef PI_ADDR_CACHE_EN
            cache_addr   <= 16'd0;
            cache_lo_vld <= 1'b0;
            cache_hi_vld <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.CMD_VALID) begin
                        cmd_type_q  <= bus.CMD_TYPE;
                        cmd_reg_q   <= bus.CMD_REG;
                        cmd_addr_q  <= bus.CMD_ADDR;
                        cmd_wdata_q <= bus.CMD_WDATA;
                        pend_q      <= start_pend_c;
                        pi_a        <= start_ph_c.a;
                        pi_wr       <= start_ph_c.wr;
                        pi_d_out    <= start_ph_c.d;
                        pi_d_oe     <= start_ph_c.wr;
                        rsp_rdata   <= 8'd0;
                        rsp_err     <= 1'b0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    pi_req  <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= S_REQ;
                end
                S_REQ, S_REL: begin
                    if ((state == S_REQ) && ack_s) begin
                        pi_req  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= S_REL;
                        if (!pi_wr) begin
                            rsp_rdata <= PI_D;
                        end
`ifdef PI_ADDR_CACHE_EN
                        // Any acknowledged address write keeps the cache coherent with the bridge.
                        if (pi_wr && (pi_a == REG_ALO)) begin
                            cache_addr[7:0] <= pi_d_out;
                            cache_lo_vld    <= 1'b1;
                        end
                        if (pi_wr && (pi_a == REG_AHI)) begin
                            cache_addr[15:8] <= pi_d_out;
                            cache_hi_vld     <= 1'b1;
                        end
`endif
                    end else if ((state == S_REL) && !ack_s) begin
                        if (rem_pend_c != '0) begin
                            pend_q   <= rem_pend_c;
                            pi_a     <= next_ph_c.a;
                            pi_wr    <= next_ph_c.wr;
                            pi_d_out <= next_ph_c.d;
                            pi_d_oe  <= next_ph_c.wr;
                            state    <= S_SETUP;
                        end else begin
                            pend_q    <= '0;
                            pi_wr     <= 1'b0;
                            pi_d_oe   <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else if (tmo_hit_c) begin
                        // Abort: the bridge state is unknown, so forget cached address bytes.
                        pi_req    <= 1'b0;
                        pi_wr     <= 1'b0;
                        pi_d_oe   <= 1'b0;
                        pend_q    <= '0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 8'd0;
                        rsp_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef PI_ADDR_CACHE_EN
                        cache_lo_vld <= 1'b0;
                        cache_hi_vld <= 1'b0;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign PI_D          = pi_d_oe ? pi_d_out : 8'hzz;
    assign bus.CMD_READY = cmd_ready;
    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_RDATA = rsp_rdata;
    assign bus.RSP_ERR   = rsp_err;
    assign bus.PI_REQ    = pi_req;
    assign bus.PI_WR     = pi_wr;
    assign bus.PI_A      = pi_a;
    assign bus.IRQ_OUT   = irq_sync[SYNC_STAGES-1];
    assign bus.BUSY      = busy;

endmodule

// File: tb/tb_pi_bus_master.sv
// tb_pi_bus_master: directed bench with a bridge+SRAM responder model and a phase monitor.
// Expected phase sequences depend on whether PI_ADDR_CACHE_EN is defined.
module tb_pi_bus_master;
    localparam int unsigned TMO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pi_bus_master_if bus();
    wire [7:0] pi_d;

    pi_bus_master #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .PI_D (pi_d)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Bridge model: A_LO/A_HI/DATA/IRQ registers in front of a 64 KiB SRAM.
    logic [7:0] sram [0:65535];
    logic [7:0] b_alo = 8'h00, b_ahi = 8'h00, b_irq = 8'h00, b_dout = 8'h00;
    logic       b_oe = 1'b0, ack_r = 1'b0;
    int         ack_delay = 0, ack_cnt = 0;
    bit         ack_stuck = 1'b0;

    assign pi_d       = b_oe ? b_dout : 8'hzz;
    assign bus.PI_ACK = ack_r;

    always @(posedge CLK) begin
        if (bus.PI_REQ && !ack_r && !ack_stuck) begin
            if (ack_cnt >= ack_delay) begin
                ack_r   <= 1'b1;
                ack_cnt <= 0;
                if (bus.PI_WR) begin
                    case (bus.PI_A)
                        2'd0: sram[{b_ahi, b_alo}] <= pi_d;
                        2'd1: b_irq <= pi_d;
                        2'd2: b_alo <= pi_d;
                        default: b_ahi <= pi_d;
                    endcase
                end else begin
                    b_oe <= 1'b1;
                    case (bus.PI_A)
                        2'd0: b_dout <= sram[{b_ahi, b_alo}];
                        2'd1: b_dout <= b_irq;
                        2'd2: b_dout <= b_alo;
                        default: b_dout <= b_ahi;
                    endcase
                end
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else if (!bus.PI_REQ) begin
            ack_cnt <= 0;
            if (ack_r) begin
                ack_r <= 1'b0;
                b_oe  <= 1'b0;
            end
        end
    end

    // Monitor: log each phase {wr, a, wdata} at REQ rise, count REQ cycles, flag instability.
    logic [10:0] phase_q[$];
    logic [10:0] hold = '0;
    logic [10:0] cur;
    logic        prev_req = 1'b0;
    int          req_cycles = 0;
    int          stab_err = 0;

    always @(posedge CLK) begin
        cur = {bus.PI_WR, bus.PI_A, (bus.PI_WR ? pi_d : 8'h00)};
        if (bus.PI_REQ) req_cycles++;
        if (bus.PI_REQ && !prev_req) begin
            hold = cur;
            phase_q.push_back(cur);
        end else if (bus.PI_REQ && (cur !== hold)) begin
            stab_err++;
        end
        prev_req = bus.PI_REQ;
    end

    function automatic logic [10:0] ph(input logic wr, input logic [1:0] a, input logic [7:0] d);
        return {wr, a, d};
    endfunction

    // Phase count plus up to three phases issued since index base.
    function automatic logic [36:0] seq_of(input int base);
        int n;
        logic [10:0] p [3];
        n = phase_q.size() - base;
        for (int i = 0; i < 3; i++) p[i] = (i < n) ? phase_q[base + i] : 11'h000;
        return {4'(n), p[0], p[1], p[2]};
    endfunction

    // Offer one command and wait (bounded) for its response.
    task automatic issue(input logic [1:0] t, input logic [1:0] r, input logic [15:0] a,
                         input logic [7:0] wd, output logic [7:0] rd, output logic er,
                         output bit done, output logic rdy_after, output int base);
        @(negedge CLK);
        base          = phase_q.size();
        bus.CMD_TYPE  = t;
        bus.CMD_REG   = r;
        bus.CMD_ADDR  = a;
        bus.CMD_WDATA = wd;
        bus.CMD_VALID = 1'b1;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        rdy_after     = bus.CMD_READY;
        done = 1'b0;
        rd   = 8'h00;
        er   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.RSP_VALID) begin
                rd   = bus.RSP_RDATA;
                er   = bus.RSP_ERR;
                done = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    logic [7:0]  rd;
    logic        er, rdy;
    bit          done;
    int          base, rc0, se0;
    logic [36:0] exp_seq;

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus.CMD_READY !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.CMD_READY); else n_pass++;
        n_checks++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.BUSY); else n_pass++;
        n_checks++; if ({bus.PI_REQ, bus.PI_WR, bus.PI_A} !== 4'b0000)
            $display("FAIL reset_pi got=%b exp=0000", {bus.PI_REQ, bus.PI_WR, bus.PI_A}); else n_pass++;
        n_checks++; if ({bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA} !== 10'd0)
            $display("FAIL reset_rsp got=%h exp=0", {bus.RSP_VALID, bus.RSP_ERR, bus.RSP_RDATA}); else n_pass++;
        n_checks++; if (bus.IRQ_OUT !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus.IRQ_OUT); else n_pass++;
        n_checks++; if (dut.pi_d_oe !== 1'b0) $display("FAIL reset_pid_z oe=%b exp=0", dut.pi_d_oe); else n_pass++;
    endtask

    task automatic test_reg_write();
        ack_delay = 3;
        se0 = stab_err;
        issue(2'b00, 2'd2, 16'h0000, 8'h55, rd, er, done, rdy, base);
        n_checks++; if (done !== 1'b1) $display("FAIL regwr_done got=%b exp=1", done); else n_pass++;
        n_checks++; if (rdy !== 1'b0) $display("FAIL regwr_ready_drop got=%b exp=0", rdy); else n_pass++;
        n_checks++; if ({er, rd} !== 9'h000) $display("FAIL regwr_rsp got=%h exp=000", {er, rd}); else n_pass++;
        exp_seq = {4'd1, ph(1, 2, 8'h55), 11'h0, 11'h0};
        n_checks++; if (seq_of(base) !== exp_seq) $display("FAIL regwr_phases got=%h exp=%h", seq_of(base), exp_seq); else n_pass++;
        n_checks++; if (stab_err !== se0) $display("FAIL regwr_stable got=%0d exp=%0d", stab_err, se0); else n_pass++;
        n_checks++; if (b_alo !== 8'h55) $display("FAIL regwr_bridge got=%h exp=55", b_alo); else n_pass++;
        ack_delay = 0;
    endtask

    task automatic test_mem_write_read();
        se0 = stab_err;
        issue(2'b10, 2'd0, 16'h1235, 8'hA5, rd, er, done, rdy, base);
        exp_seq = {4'd3, ph(1, 2, 8'h35), ph(1, 3, 8'h12), ph(1, 0, 8'hA5)};
        n_checks++; if (!done || er || seq_of(base) !== exp_seq)
            $display("FAIL memwr1 done=%b err=%b got=%h exp=%h", done, er, seq_of(base), exp_seq); else n_pass++;

        issue(2'b10, 2'd0, 16'h1234, 8'h78, rd, er, done, rdy, base);
`ifdef PI_ADDR_CACHE_EN
        exp_seq = {4'd2, ph(1, 2, 8'h34), ph(1, 0, 8'h78), 11'h0};
`else
        exp_seq = {4'd3, ph(1, 2, 8'h34), ph(1, 3, 8'h12), ph(1, 0, 8'h78)};
`endif
        n_checks++; if (!done || er || seq_of(base) !== exp_seq)
            $display("FAIL memwr2 done=%b err=%b got=%h exp=%h", done, er, seq_of(base), exp_seq); else n_pass++;
        n_checks++; if ({sram[16'h1234], sram[16'h1235]} !== 16'h78A5)
            $display("FAIL memwr_sram got=%h exp=78a5", {sram[16'h1234], sram[16'h1235]}); else n_pass++;

        issue(2'b11, 2'd0, 16'h1234, 8'h00, rd, er, done, rdy, base);
        n_checks++; if (!done || {er, rd} !== 9'h078) $display("FAIL memrd1_data done=%b got=%h exp=078", done, {er, rd}); else n_pass++;
`ifdef PI_ADDR_CACHE_EN
        exp_seq = {4'd1, ph(0, 0, 8'h00), 11'h0, 11'h0};
`else
        exp_seq = {4'd3, ph(1, 2, 8'h34), ph(1, 3, 8'h12), ph(0, 0, 8'h00)};
`endif
        n_checks++; if (seq_of(base) !== exp_seq) $display("FAIL memrd1_phases got=%h exp=%h", seq_of(base), exp_seq); else n_pass++;
        n_checks++; if (stab_err !== se0) $display("FAIL mem_stable got=%0d exp=%0d", stab_err, se0); else n_pass++;
    endtask

    task automatic test_cache();
        issue(2'b11, 2'd0, 16'h1235, 8'h00, rd, er, done, rdy, base);
        n_checks++; if (!done || {er, rd} !== 9'h0A5) $display("FAIL memrd2_data done=%b got=%h exp=0a5", done, {er, rd}); else n_pass++;
`ifdef PI_ADDR_CACHE_EN
        exp_seq = {4'd2, ph(1, 2, 8'h35), ph(0, 0, 8'h00), 11'h0};
`else
        exp_seq = {4'd3, ph(1, 2, 8'h35), ph(1, 3, 8'h12), ph(0, 0, 8'h00)};
`endif
        n_checks++; if (seq_of(base) !== exp_seq) $display("FAIL memrd2_phases got=%h exp=%h", seq_of(base), exp_seq); else n_pass++;
    endtask

    task automatic test_timeout();
        ack_stuck = 1'b1;
        rc0 = req_cycles;
        issue(2'b11, 2'd0, 16'h1235, 8'h00, rd, er, done, rdy, base);
        n_checks++; if (!done || {er, rd} !== 9'h100) $display("FAIL tmo_rsp done=%b got=%h exp=100", done, {er, rd}); else n_pass++;
        n_checks++; if (req_cycles - rc0 !== 8) $display("FAIL tmo_req_cycles got=%0d exp=8", req_cycles - rc0); else n_pass++;
`ifdef PI_ADDR_CACHE_EN
        exp_seq = {4'd1, ph(0, 0, 8'h00), 11'h0, 11'h0};
`else
        exp_seq = {4'd1, ph(1, 2, 8'h35), 11'h0, 11'h0};
`endif
        n_checks++; if (seq_of(base) !== exp_seq) $display("FAIL tmo_phases got=%h exp=%h", seq_of(base), exp_seq); else n_pass++;
        n_checks++; if ({bus.PI_REQ, dut.pi_d_oe} !== 2'b00) $display("FAIL tmo_release got=%b exp=00", {bus.PI_REQ, dut.pi_d_oe}); else n_pass++;
        ack_stuck = 1'b0;
        issue(2'b11, 2'd0, 16'h1235, 8'h00, rd, er, done, rdy, base);
        exp_seq = {4'd3, ph(1, 2, 8'h35), ph(1, 3, 8'h12), ph(0, 0, 8'h00)};
        n_checks++; if (!done || {er, rd} !== 9'h0A5 || seq_of(base) !== exp_seq)
            $display("FAIL tmo_resend got=%h seq=%h exp=0a5 seq=%h", {er, rd}, seq_of(base), exp_seq); else n_pass++;
    endtask

    task automatic test_reset_midway();
        bit saw_req;
        @(negedge CLK);
        bus.CMD_TYPE  = 2'b10;
        bus.CMD_REG   = 2'd0;
        bus.CMD_ADDR  = 16'h4000;
        bus.CMD_WDATA = 8'h99;
        bus.CMD_VALID = 1'b1;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.PI_REQ) begin
                saw_req = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        n_checks++; if (saw_req !== 1'b1) $display("FAIL rstmid_req_seen got=%b exp=1", saw_req); else n_pass++;
        RST = 1'b1;
        #1;
        n_checks++; if ({bus.PI_REQ, dut.pi_d_oe, bus.CMD_READY, bus.BUSY} !== 4'b0010)
            $display("FAIL rstmid_abort got=%b exp=0010", {bus.PI_REQ, dut.pi_d_oe, bus.CMD_READY, bus.BUSY}); else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        issue(2'b10, 2'd0, 16'h4000, 8'h99, rd, er, done, rdy, base);
        exp_seq = {4'd3, ph(1, 2, 8'h00), ph(1, 3, 8'h40), ph(1, 0, 8'h99)};
        n_checks++; if (!done || er || seq_of(base) !== exp_seq)
            $display("FAIL rstmid_next done=%b err=%b got=%h exp=%h", done, er, seq_of(base), exp_seq); else n_pass++;
        n_checks++; if (sram[16'h4000] !== 8'h99) $display("FAIL rstmid_sram got=%h exp=99", sram[16'h4000]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rd [3];
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h40;
        exp_rd[2] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] r;
            r = (i == 0) ? 2'd2 : ((i == 1) ? 2'd3 : 2'd0);
            issue(2'b01, r, 16'h0000, 8'h00, rd, er, done, rdy, base);
            n_checks++; if (!done || {er, rd} !== {1'b0, exp_rd[i]} || seq_of(base) !== {4'd1, ph(0, r, 8'h00), 22'h0})
                $display("FAIL b2b_read%0d got=%h seq=%h exp=%h", i, {er, rd}, seq_of(base), {1'b0, exp_rd[i]}); else n_pass++;
        end
    endtask

    task automatic test_irq();
        @(negedge CLK);
        bus.PI_IRQ = 1'b1;
        @(negedge CLK);
        n_checks++; if (bus.IRQ_OUT !== 1'b0) $display("FAIL irq_rise_early got=%b exp=0", bus.IRQ_OUT); else n_pass++;
        @(negedge CLK);
        n_checks++; if (bus.IRQ_OUT !== 1'b1) $display("FAIL irq_rise got=%b exp=1", bus.IRQ_OUT); else n_pass++;
        issue(2'b00, 2'd1, 16'h0000, 8'h0F, rd, er, done, rdy, base);
        fork
            begin
                issue(2'b01, 2'd1, 16'h0000, 8'h00, rd, er, done, rdy, base);
            end
            begin
                repeat (3) @(negedge CLK);
                bus.PI_IRQ = 1'b0;
                @(negedge CLK);
                n_checks++; if (bus.IRQ_OUT !== 1'b1) $display("FAIL irq_fall_early got=%b exp=1", bus.IRQ_OUT); else n_pass++;
                @(negedge CLK);
                n_checks++; if ({bus.IRQ_OUT, bus.BUSY} !== 2'b01) $display("FAIL irq_fall_busy got=%b exp=01", {bus.IRQ_OUT, bus.BUSY}); else n_pass++;
            end
        join
        n_checks++; if (!done || {er, rd} !== 9'h00F) $display("FAIL irq_regrd got=%h exp=00f", {er, rd}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_TYPE  = 2'b00;
        bus.CMD_REG   = 2'd0;
        bus.CMD_ADDR  = 16'h0000;
        bus.CMD_WDATA = 8'h00;
        bus.PI_IRQ    = 1'b0;
        test_reset();
        test_reg_write();
        test_mem_write_read();
        test_cache();
        test_timeout();
        test_reset_midway();
        test_back_to_back();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
